// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM encoding, port ids, byte-lane helpers.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_RESP   = 2'd2;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_SDT   = 1'b1;

  function automatic logic [3:0] lane_en(input logic is_byte, input logic [1:0] off);
    return is_byte ? (4'b0001 << off) : 4'b1111;
  endfunction

  function automatic logic [31:0] lane_sel(input logic [31:0] d, input logic is_byte,
                                           input logic [1:0] off);
    logic [7:0] b;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    return is_byte ? {24'h0, b} : d;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Valid/ready data-memory bus with byte-lane enables; master = arbiter, slave = RAM.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              en;
  logic              we;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output en, we, be, addr, wdata, input rdata, ready);
  modport slave  (input en, we, be, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arb_slot.sv
// One-entry request capture buffer; a request arriving in the clear cycle refills the slot.
module mem_arb_slot #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic              is_byte,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic              full,
  output logic              slot_we,
  output logic              slot_byte,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_wdata
);

  logic load;

  // A request while full and not being cleared is dropped.
  assign load = req && (!full || clear);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full       <= 1'b0;
      slot_we    <= 1'b0;
      slot_byte  <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= '0;
    end else if (load) begin
      full       <= 1'b1;
      slot_we    <= we;
      slot_byte  <= is_byte;
      slot_addr  <= addr;
      slot_wdata <= wdata;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between fetch (port 0) and SDT (port 1).
// Optional access timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_byte,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ack,
  output logic              p0_busy,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_byte,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ack,
  output logic              p1_busy,
  mem_arbiter_if.master     mem,
  output logic              arb_err
);

  state_t            state;
  logic              gnt, last_gnt, next_gnt;
  logic [1:0]        full, s_we, s_byte;
  logic [ADDR_W-1:0] s0_addr, s1_addr, sel_addr;
  logic [DATA_W-1:0] s0_wdata, s1_wdata, sel_wdata, rd_lane;
  logic              sel_we, sel_byte, in_access;

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .req(p0_req), .we(p0_we), .is_byte(p0_byte),
    .addr(p0_addr), .wdata(p0_wdata), .clear(p0_ack), .full(full[0]),
    .slot_we(s_we[0]), .slot_byte(s_byte[0]), .slot_addr(s0_addr), .slot_wdata(s0_wdata)
  );

  mem_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .req(p1_req), .we(p1_we), .is_byte(p1_byte),
    .addr(p1_addr), .wdata(p1_wdata), .clear(p1_ack), .full(full[1]),
    .slot_we(s_we[1]), .slot_byte(s_byte[1]), .slot_addr(s1_addr), .slot_wdata(s1_wdata)
  );

  // Slot contents stay frozen while granted, so the bus is driven straight from the slot.
  assign sel_we    = gnt ? s_we[1]   : s_we[0];
  assign sel_byte  = gnt ? s_byte[1] : s_byte[0];
  assign sel_addr  = gnt ? s1_addr   : s0_addr;
  assign sel_wdata = gnt ? s1_wdata  : s0_wdata;
  assign next_gnt  = (&full) ? ~last_gnt : full[1];
  assign rd_lane   = lane_sel(mem.rdata, sel_byte, sel_addr[1:0]);
  assign in_access = (state == ST_ACCESS);

  assign mem.en    = in_access;
  assign mem.we    = in_access && sel_we;
  assign mem.be    = in_access ? lane_en(sel_byte, sel_addr[1:0]) : 4'b0000;
  assign mem.addr  = in_access ? {sel_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem.wdata = in_access ? (sel_byte ? {4{sel_wdata[7:0]}} : sel_wdata) : '0;

  assign p0_ack  = (state == ST_RESP) && (gnt == PORT_FETCH);
  assign p1_ack  = (state == ST_RESP) && (gnt == PORT_SDT);
  assign p0_busy = full[0];
  assign p1_busy = full[1];

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_RAW = $clog2(TIMEOUT + 1);
  localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 16) ? 16 : CNT_RAW);
  logic [CNT_W-1:0] cnt;
  logic             timed_out;
  assign arb_err = (state == ST_RESP) && timed_out;
`else
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= PORT_FETCH;
      last_gnt <= PORT_SDT;
      p0_rdata <= '0;
      p1_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt       <= '0;
      timed_out <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (|full) begin
            gnt      <= next_gnt;
            last_gnt <= next_gnt;
            state    <= ST_ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt       <= '0;
            timed_out <= 1'b0;
`endif
          end
        end
        ST_ACCESS: begin
          // Read data lands in the port register on the way into RESP so it is valid with ack.
          if (mem.ready) begin
            if (!sel_we) begin
              if (gnt) p1_rdata <= rd_lane;
              else     p0_rdata <= rd_lane;
            end
            state <= ST_RESP;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            if (!sel_we) begin
              if (gnt) p1_rdata <= '0;
              else     p0_rdata <= '0;
            end
            timed_out <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 (instruction fetch) and port 1 (single data transfer unit).
- Each port issues a one-cycle request pulse. The block captures the request into a one-entry slot and arbitrates round-robin.
- It drives a valid/ready memory bus with byte lanes, then returns read data plus a one-cycle ack to the originating port.
- It sits between the core's load/store and fetch logic and the data RAM.

Parameters:
- ADDR_W, 32, address width for ports and memory bus.
- DATA_W, 32, data width; fixed at 32 for byte-lane logic (4 lanes).
- TIMEOUT, 255, maximum ACCESS cycles without mem_ready; used only with the optional feature.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request pulse; fields below sampled in the same cycle.
- p0_we  in  1  1=write, 0=read.
- p0_byte  in  1  1=byte access, 0=word access.
- p0_addr  in  ADDR_W  byte address.
- p0_wdata  in  DATA_W  write data; byte writes use [7:0].
- p0_rdata  out  DATA_W  read result, held until the next port 0 ack.
- p0_ack  out  1  one-cycle completion pulse.
- p0_busy  out  1  slot occupied or transaction in flight.
- p1_req, p1_we, p1_byte, p1_addr, p1_wdata, p1_rdata, p1_ack, p1_busy: identical to port 0, for port 1.
- mem_en  out  1  memory request valid.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte-lane enables.
- mem_addr  out  ADDR_W  word-aligned address ([1:0]=0).
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid with mem_ready.
- mem_ready  in  1  memory accepts/completes the current request.
- arb_err  out  1  timeout pulse, coincident with ack.

Behaviour:
- Reset: every output is 0, both slots are empty, state=IDLE, last_gnt=1 (so port 0 wins the first tie). Reset asserted mid-transaction aborts it: mem_en drops immediately, no ack is issued, pending requests are lost.
- Capture: on a req pulse with the slot empty, {we, byte, addr, wdata} are registered and the slot is marked full at the clock edge.
  - A req while busy=1 is a protocol violation and is ignored.
  - A req in the same cycle as that port's ack is accepted; refill wins over clear.
- busy is high from the cycle after the req until the cycle after the ack.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if exactly one slot is full, grant that port. If both are full, grant the port not equal to last_gnt, then set last_gnt to the grant. Move to ACCESS.
  - ACCESS: mem_en=1 with the granted fields, held stable until mem_ready=1 is sampled. On mem_ready, capture the read data and move to RESP.
  - RESP: pulse the granted port's ack for 1 cycle, update its rdata (reads only), clear its slot, return to IDLE.
- Zero-wait latency: req in cycle N, mem_en high in N+2, ack and rdata in N+3. Each memory wait state adds one cycle.
- Word access: mem_addr = {addr[ADDR_W-1:2], 2'b00}, mem_be=4'b1111, mem_wdata=wdata. Read returns mem_rdata unchanged; no rotation for unaligned addresses.
- Byte access: mem_be is one-hot at bit addr[1:0], and mem_wdata is wdata[7:0] replicated into all 4 lanes. Read returns the selected lane zero-extended to 32 bits.
- Writes still ack; rdata is left unchanged.
- Back-to-back requests: no idle bubble beyond the RESP→IDLE cycle. Worst-case starvation for a port is one transaction.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter (sized by TIMEOUT) clears on entry to ACCESS and increments each ACCESS cycle without mem_ready.
  - When the counter reaches TIMEOUT, mem_en drops and the FSM moves to RESP. rdata is forced to 0 for reads, and arb_err pulses together with ack.
- Undefined: no counter; ACCESS waits indefinitely; arb_err is tied to 0.

Decomposition:
- Package mem_arb_pkg: FSM state encoding (IDLE/ACCESS/RESP), port index constants PORT_FETCH=0 and PORT_SDT=1, lane-enable and lane-select helper functions.
- Sub-module mem_arb_slot: one-entry request capture buffer with full flag and refill-over-clear priority, instantiated twice.

Test Plan:
- Single read, port 0:
  - Stimulus: p0 read word at 0x100, mem_rdata=0xCAFEF00D, ready same cycle.
  - Required: mem_en in N+2 with mem_addr=0x100 and be=1111; p0_ack in N+3 with p0_rdata=0xCAFEF00D.
- Byte write, port 1:
  - Stimulus: p1 byte write to 0x203 with wdata=0x000000A5.
  - Required: mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x200, mem_we=1.
- Byte read:
  - Stimulus: p1 byte read at 0x201, mem_rdata=0x11223344.
  - Required: p1_rdata=0x00000033.
- Contention:
  - Stimulus: both ports pulse req in the same cycle, then both re-request immediately after each ack.
  - Required: grant order is p0, p1, p0, p1; no ack is lost.
- Wait states and reset:
  - Stimulus: mem_ready held low for 5 cycles.
  - Required: mem_en and its fields stay stable for 6 cycles; ack follows ready.
  - Stimulus: assert rst_n low mid-ACCESS.
  - Required: mem_en drops asynchronously, no ack, busy=0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=4:
  - Stimulus: mem_ready never asserts.
  - Required: after 4 ACCESS cycles, ack and arb_err pulse together with rdata=0, and the FSM returns to IDLE.
